// File: rtl/half_pkg.sv
// Shared half-precision field constants, the argmax FSM state type and a NaN test.
package half_pkg;

  localparam int HALF_SIGN_BIT = 15;
  localparam int HALF_EXP_MSB  = 14;
  localparam int HALF_EXP_LSB  = 10;
  localparam int HALF_MANT_MSB = 9;
  localparam int HALF_MANT_LSB = 0;

  localparam logic [15:0] HALF_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  function automatic logic is_nan(input logic [15:0] h);
    return (h[HALF_EXP_MSB:HALF_EXP_LSB] == 5'h1F) &&
           (h[HALF_MANT_MSB:HALF_MANT_LSB] != 10'h000);
  endfunction

endpackage

// File: rtl/half_gt.sv
// Combinational half-precision strict greater-than: gt = (a > b).
// Signed zeros are ordered (+0 > -0); NaNs are treated as plain bit patterns.
module half_gt
  import half_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt
);

  logic [14:0] w_mag_a;
  logic [14:0] w_mag_b;

  assign w_mag_a = a[HALF_EXP_MSB:HALF_MANT_LSB];
  assign w_mag_b = b[HALF_EXP_MSB:HALF_MANT_LSB];

  // {exp,mant} is monotonic in magnitude, so a plain unsigned compare orders it.
  always_comb begin
    if (a[HALF_SIGN_BIT] != b[HALF_SIGN_BIT]) begin
      gt = b[HALF_SIGN_BIT];
    end else if (!a[HALF_SIGN_BIT]) begin
      gt = (w_mag_a > w_mag_b);
    end else begin
      gt = (w_mag_a < w_mag_b);
    end
  end

endmodule

// File: rtl/half_argmax_seq.sv
// Streaming argmax over a half-precision vector with a held result handshake.
// Define HALF_ARGMAX_NAN_EN to skip NaN elements and report them on nan_seen.
module half_argmax_seq
  import half_pkg::*;
#(
  parameter int LEN_MAX = 256,
  parameter int IDX_W   = $clog2(LEN_MAX)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [IDX_W:0]   cfg_len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_max,
  output logic [IDX_W-1:0] m_idx,
  output logic             len_err,
  output logic             nan_seen
);

  argmax_state_t    r_state;
  argmax_state_t    w_state_nxt;
  logic [IDX_W:0]   r_len;
  logic [IDX_W:0]   r_cnt;
  logic [15:0]      r_max;
  logic [IDX_W-1:0] r_idx;
  logic             r_have;
  logic             r_len_err;

  logic w_len_ok;
  logic w_acc;
  logic w_last;
  logic w_nan;
  logic w_gt;
  logic w_load;

  assign w_len_ok = (cfg_len != '0) && (cfg_len <= (IDX_W+1)'(LEN_MAX));
  assign w_acc    = (r_state == RUN) && s_valid;
  assign w_last   = (r_cnt == r_len - 1'b1);
  assign w_load   = w_acc && !w_nan && (!r_have || w_gt);

  half_gt u_gt (
    .a  (s_data),
    .b  (r_max),
    .gt (w_gt)
  );

  // NOTE: synchronous reset is used here because the surrounding codebase resets
  // this way; rstn is therefore only sampled on the rising clock edge.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start)            w_state_nxt = w_len_ok ? RUN : DONE;
      RUN:  if (w_acc && w_last)  w_state_nxt = DONE;
      DONE: if (m_ready)          w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_max     <= 16'h0000;
      r_idx     <= '0;
      r_have    <= 1'b0;
      r_len_err <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_len     <= cfg_len;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_have    <= 1'b0;
      r_len_err <= !w_len_ok;
`ifdef HALF_ARGMAX_NAN_EN
      // Preloaded so an all-NaN vector reports a quiet NaN at index 0.
      r_max     <= w_len_ok ? HALF_QNAN : 16'h0000;
`else
      r_max     <= 16'h0000;
`endif
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_load) begin
        r_max  <= s_data;
        r_idx  <= r_cnt[IDX_W-1:0];
        r_have <= 1'b1;
      end
    end
  end

`ifdef HALF_ARGMAX_NAN_EN
  logic r_nan_seen;

  assign w_nan = is_nan(s_data);

  always_ff @(posedge clk) begin
    if (!rstn)                         r_nan_seen <= 1'b0;
    else if (r_state == IDLE && start) r_nan_seen <= 1'b0;
    else if (w_acc && w_nan)           r_nan_seen <= 1'b1;
  end

  assign nan_seen = r_nan_seen;
`else
  assign w_nan    = 1'b0;
  assign nan_seen = 1'b0;
`endif

  assign busy    = (r_state != IDLE);
  assign s_ready = (r_state == RUN);
  assign m_valid = (r_state == DONE);
  assign m_max   = r_max;
  assign m_idx   = r_idx;
  assign len_err = r_len_err;

endmodule

// File: tb/tb_half_argmax_seq.sv
// Self-checking bench for half_argmax_seq: expected results are queued as each
// vector is driven and compared when the DUT presents m_valid.
module tb_half_argmax_seq;

  localparam int LEN_MAX = 256;
  localparam int IDX_W   = 8;
`ifdef HALF_ARGMAX_NAN_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [IDX_W:0]   cfg_len;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_data;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      m_max;
  logic [IDX_W-1:0] m_idx;
  logic             len_err;
  logic             nan_seen;

  half_argmax_seq #(.LEN_MAX(LEN_MAX)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .cfg_len  (cfg_len),
    .busy     (busy),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_max    (m_max),
    .m_idx    (m_idx),
    .len_err  (len_err),
    .nan_seen (nan_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] max;
    logic [7:0]  idx;
    logic        len_err;
    logic        nan;
  } res_t;

  res_t        sb_q[$];
  logic [15:0] vec[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Maps a half to an unsigned key whose integer order is the required ordering.
  function automatic logic [15:0] order_key(input logic [15:0] h);
    return h[15] ? ~h : (h ^ 16'h8000);
  endfunction

  function automatic bit model_nan(input logic [15:0] h);
    return NAN_EN && (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction

  task automatic push_model();
    res_t r;
    bit   have = 0;
    r.max = NAN_EN ? 16'h7E00 : 16'h0000;
    r.idx = 0;
    r.len_err = 0;
    r.nan = 0;
    for (int i = 0; i < vec.size(); i++) begin
      if (model_nan(vec[i])) r.nan = 1;
      else if (!have || order_key(vec[i]) > order_key(r.max)) begin
        r.max = vec[i];
        r.idx = 8'(i);
        have  = 1;
      end
    end
    sb_q.push_back(r);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_s_ready"},  32'(s_ready),  0);
    check({tag, "_m_valid"},  32'(m_valid),  0);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_len_err"},  32'(len_err),  0);
    check({tag, "_nan_seen"}, 32'(nan_seen), 0);
    check({tag, "_m_max"},    32'(m_max),    0);
    check({tag, "_m_idx"},    32'(m_idx),    0);
  endtask

  task automatic pulse_start(input int len);
    start   = 1'b1;
    cfg_len = (IDX_W+1)'(len);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Drives vec[0..count-1]; returns #1 after the edge that accepted the last one.
  task automatic send_elems(input int count, input bit rand_valid, input string tag);
    for (int i = 0; i < count; i++) begin
      bit accepted = 0;
      int guard    = 0;
      while (!accepted) begin
        logic rdy;
        s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = vec[i];
        rdy     = s_ready;
        if (rdy !== 1'b1) check({tag, "_s_ready_run"}, 32'(rdy), 1);
        @(posedge clk); #1;
        accepted = s_valid && rdy;
        if (++guard > 100) begin
          check({tag, "_accept_timeout"}, 0, 1);
          s_valid = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    res_t e;
    int   guard = 0;
    while (m_valid !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (m_valid !== 1'b1) begin
      check({tag, "_result_timeout"}, 32'(m_valid), 1);
      return;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_m_max"},    32'(m_max),    32'(e.max));
    check({tag, "_m_idx"},    32'(m_idx),    32'(e.idx));
    check({tag, "_len_err"},  32'(len_err),  32'(e.len_err));
    check({tag, "_nan_seen"}, 32'(nan_seen), 32'(e.nan));
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(busy), 0);
  endtask

  task automatic run_vector(input bit rand_valid, input string tag);
    pulse_start(vec.size());
    push_model();
    send_elems(vec.size(), rand_valid, tag);
    check({tag, "_latency"}, 32'(m_valid), 1);
    collect(tag);
  endtask

  task automatic run_len_err(input int len, input string tag);
    res_t e;
    e.max = 0; e.idx = 0; e.len_err = 1; e.nan = 0;
    s_valid = 1'b1;
    s_data  = 16'h7BFF;
    pulse_start(len);
    sb_q.push_back(e);
    check({tag, "_done_next"}, 32'(m_valid), 1);
    check({tag, "_no_ready"},  32'(s_ready), 0);
    check({tag, "_busy"},      32'(busy),    1);
    s_valid = 1'b0;
    collect(tag);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; cfg_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("por");
    rstn = 1'b1;
    @(posedge clk); #1;

    vec = '{16'h3C00, 16'h4000, 16'h3E00, 16'h4000};
    run_vector(0, "tie");

    vec = '{16'hBC00, 16'hC000, 16'hB800};
    run_vector(0, "neg");

    // Signed zeros, then hold DONE with start asserted and no m_ready.
    vec = '{16'h8000, 16'h0000};
    pulse_start(2);
    push_model();
    send_elems(2, 0, "zero");
    start   = 1'b1;
    cfg_len = 9'd3;
    for (int c = 0; c < 5; c++) begin
      check("hold_m_valid", 32'(m_valid), 1);
      check("hold_m_max",   32'(m_max),   32'h0000);
      check("hold_m_idx",   32'(m_idx),   1);
      @(posedge clk); #1;
    end
    collect("zero");
    start = 1'b0;
    @(posedge clk); #1;
    check("restart_ignored_busy", 32'(busy), 0);

    run_len_err(0, "len0");
    run_len_err(LEN_MAX + 1, "len_over");

    vec = '{16'h5000};
    run_vector(0, "len1");

    // Abort a random-valid vector with reset after five accepts.
    vec = '{16'h3800, 16'h4400, 16'hC400, 16'h4600, 16'h4500, 16'h3000, 16'h4700, 16'h0001};
    pulse_start(8);
    send_elems(5, 1, "abort");
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("mid_reset");
    rstn = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("post_reset");

    vec = '{16'hC800, 16'h3555, 16'h4B00, 16'h0000, 16'h4B00, 16'hFBFF, 16'h4AFF, 16'h8001};
    run_vector(1, "fresh8");

    vec = '{16'h7E01, 16'h3C00, 16'hFE00};
    run_vector(1, "nan_mix");

    vec = '{16'h7E01, 16'h7C01};
    run_vector(0, "nan_all");

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
